// File: rtl/mux_arb_2x1_pkg.sv
// Shared definitions for the two-lane stream merger.
// Holds the default data width, the lane identifiers used on selOut and in the
// arbiter's last-grant register, and the reset value of that register.
package mux_arb_2x1_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Last-grant starts at lane 1 so lane 0 wins the first contention.
  localparam logic LAST_RESET = LANE1;

endpackage : mux_arb_2x1_pkg

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, one per input lane.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low reset (empties the FIFO)
//   wr_en    write strobe; ignored while full
//   wr_data  data to write
//   rd_en    pop strobe; ignored while empty
//   rd_data  head entry, valid whenever empty==0
//   empty    no entries held
//   full     Depth entries held (from registered count only)
module sync_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DataWidth-1:0] rd_data,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 push, pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a same-cycle pop does not
  // make room for a write in that cycle.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule : sync_fifo

// File: rtl/mux_arb_2x1.sv
// Two-lane to one-lane stream merger.
// Each lane feeds its own FIFO; a round-robin arbiter drains the FIFOs into a
// registered output stage with valid/ready backpressure, tagging every byte
// with its source lane.
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   dataIn0/validIn0     lane 0 data and write strobe
//   dataIn1/validIn1     lane 1 data and write strobe
//   full0/full1          lane FIFO holds FIFO_DEPTH entries
//   outReady             downstream accepts dataOut this cycle
//   dataOut/selOut       registered merged data and its source lane
//   validOut             registered output-valid
module mux_arb_2x1
  import mux_arb_2x1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn0,
  input  logic                  validIn0,
  input  logic [DATA_WIDTH-1:0] dataIn1,
  input  logic                  validIn1,
  output logic                  full0,
  output logic                  full1,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  selOut
);

  logic [DATA_WIDTH-1:0] rd_data0, rd_data1;
  logic                  empty0, empty1;
  logic                  pop0, pop1;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sel_q, sel_d;
  logic                  last_q, last_d;

  logic                  load;
  logic                  grant;

  sync_fifo #(
    .DataWidth(DATA_WIDTH),
    .Depth    (FIFO_DEPTH)
  ) u_fifo0 (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (validIn0),
    .wr_data(dataIn0),
    .rd_en  (pop0),
    .rd_data(rd_data0),
    .empty  (empty0),
    .full   (full0)
  );

  sync_fifo #(
    .DataWidth(DATA_WIDTH),
    .Depth    (FIFO_DEPTH)
  ) u_fifo1 (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (validIn1),
    .wr_data(dataIn1),
    .rd_en  (pop1),
    .rd_data(rd_data1),
    .empty  (empty1),
    .full   (full1)
  );

  always_comb begin
    grant  = LANE0;
    load   = 1'b0;
    pop0   = 1'b0;
    pop1   = 1'b0;
    data_d = data_q;
    sel_d  = sel_q;
    valid_d = valid_q;
    last_d = last_q;

    // Alternate only under contention; a lone non-empty lane always wins.
    if (!empty0 && !empty1) begin
      grant = !last_q;
    end else if (!empty1) begin
      grant = LANE1;
    end

    load = (!valid_q || outReady) && (!empty0 || !empty1);

    if (load) begin
      pop0    = (grant == LANE0);
      pop1    = (grant == LANE1);
      data_d  = (grant == LANE1) ? rd_data1 : rd_data0;
      sel_d   = grant;
      valid_d = 1'b1;
      last_d  = grant;
    end else if (valid_q && outReady) begin
      // Drained with nothing queued: drop valid, keep data/sel as they were.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= LANE0;
      last_q  <= LAST_RESET;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign selOut   = sel_q;

endmodule : mux_arb_2x1

// File: tb/tb_mux_arb_2x1.sv
// Self-checking bench for mux_arb_2x1: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_mux_arb_2x1;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] dataIn0, dataIn1;
  logic          validIn0, validIn1;
  logic          full0, full1;
  logic          outReady;
  logic [DW-1:0] dataOut;
  logic          validOut;
  logic          selOut;

  always #5 clk = ~clk;

  mux_arb_2x1 #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dataIn0 (dataIn0),
    .validIn0(validIn0),
    .dataIn1 (dataIn1),
    .validIn1(validIn1),
    .full0   (full0),
    .full1   (full1),
    .outReady(outReady),
    .dataOut (dataOut),
    .validOut(validOut),
    .selOut  (selOut)
  );

  // Reference model: one queue per lane plus the visible output register.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_sel;
  logic          m_last;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_sel   = 1'b0;
    m_last  = 1'b1;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit f0, f1, can_load, g;
    if (!reset) begin
      model_reset();
      return;
    end
    f0 = (q0.size() == DEPTH);
    f1 = (q1.size() == DEPTH);
    can_load = (!m_valid || outReady) && (q0.size() > 0 || q1.size() > 0);
    if (can_load) begin
      if (q0.size() > 0 && q1.size() > 0) g = !m_last;
      else g = (q1.size() > 0);
      m_data  = g ? q1.pop_front() : q0.pop_front();
      m_sel   = g;
      m_valid = 1'b1;
      m_last  = g;
    end else if (m_valid && outReady) begin
      m_valid = 1'b0;
    end
    if (validIn0 && !f0) q0.push_back(dataIn0);
    if (validIn1 && !f1) q1.push_back(dataIn1);
  endtask

  task automatic compare_all();
    check("validOut", {7'd0, validOut}, {7'd0, m_valid});
    check("dataOut",  dataOut, m_data);
    check("selOut",   {7'd0, selOut}, {7'd0, m_sel});
    check("full0",    {7'd0, full0}, {7'd0, 1'(q0.size() == DEPTH)});
    check("full1",    {7'd0, full1}, {7'd0, 1'(q1.size() == DEPTH)});
  endtask

  // One clock: inputs are already applied; update model at the edge, sample #1 later.
  task automatic step(input bit v0, input logic [DW-1:0] d0, input bit v1,
                      input logic [DW-1:0] d1, input bit rdy);
    validIn0 = v0;
    dataIn0  = d0;
    validIn1 = v1;
    dataIn1  = d1;
    outReady = rdy;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 8'h00, 1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    validIn0 = 1'b0;
    validIn1 = 1'b0;
    dataIn0  = '0;
    dataIn1  = '0;
    outReady = 1'b0;
    model_reset();
    idle(1'b0);
    idle(1'b0);
    reset = 1'b1;

    // Reset mid-traffic: queued bytes must vanish.
    step(1'b1, 8'hE1, 1'b1, 8'hF1, 1'b0);
    step(1'b1, 8'hE2, 1'b1, 8'hF2, 1'b0);
    do_reset();
    check("rst_valid", {7'd0, validOut}, 8'h00);
    check("rst_data", dataOut, 8'h00);
    check("rst_full", {6'd0, full1, full0}, 8'h00);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("rst_nodata", {7'd0, validOut}, 8'h00);

    // Single lane, one cycle latency.
    step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
    check("single_11", dataOut, 8'h11);
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    check("single_22", dataOut, 8'h22);
    idle(1'b1);
    check("single_33", dataOut, 8'h33);
    idle(1'b1);
    idle(1'b1);

    // Round-robin from reset: lane 0 wins first.
    do_reset();
    step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
    step(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0);
    check("rr_A0", dataOut, 8'hA0);
    idle(1'b1);
    check("rr_B0", {selOut, dataOut[6:0]}, {1'b1, 7'h30});
    idle(1'b1);
    check("rr_A1", dataOut, 8'hA1);
    idle(1'b1);
    check("rr_B1", dataOut, 8'hB1);
    idle(1'b1);

    // Full / drop on lane 1.
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b0, 8'h00, 1'b1, 8'(i), 1'b0);
    check("drop_full1", {7'd0, full1}, 8'h01);
    check("drop_head", dataOut, 8'h01);
    for (int i = 2; i <= 5; i++) begin
      idle(1'b1);
      check("drop_seq", dataOut, 8'(i));
    end
    idle(1'b1);
    check("drop_no06", {7'd0, validOut}, 8'h00);

    // Backpressure hold.
    do_reset();
    step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("bp_hold", dataOut, 8'h5A);
    end
    idle(1'b1);
    check("bp_next", dataOut, 8'h77);
    idle(1'b1);

    // Write with simultaneous pop on a full lane is rejected, retry accepted.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
    check("sp_full", {7'd0, full0}, 8'h01);
    step(1'b1, 8'hC0, 1'b0, 8'h00, 1'b1);
    check("sp_reject", {7'd0, full0}, 8'h00);
    step(1'b1, 8'hC0, 1'b0, 8'h00, 1'b0);
    check("sp_retry", {7'd0, full0}, 8'h01);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Random traffic with rare resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 3) != 0));
      reset = 1'b1;
    end
    for (int i = 0; i < 12; i++) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mux_arb_2x1
